tone_sequencer: RTL and testbench
=================================

Name: tone_sequencer

Overview:
- Parametrised successor to the fixed note-period lookup used by the game audio.
- Holds a writable melody RAM of note entries and steps through it on a duration tick.
- Converts each entry's note index and octave into a square-wave half-period and drives a 1-bit tone output to the speaker/PWM pin.
- Supports rests, octave shift, loop/one-shot playback, start/stop control and a completion pulse.

Parameters:
- SEQ_AW, 5, melody RAM address width; depth = 2^SEQ_AW entries.
- HP_W, 32, width of the half-period counter and pitch values.
- TICK_DIV, 2500000, clock cycles per duration tick (50 ms at 50 MHz); must be >= 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  melody RAM write strobe
- wr_addr  in  SEQ_AW  write address
- wr_data  in  10  entry {note[9:6], octave[5:4], dur[3:0]}
- start  in  1  single-cycle start request
- stop  in  1  single-cycle stop request; priority over start
- loop_en  in  1  1 = restart at index 0 after end of song
- tone_out  out  1  square-wave audio output
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on natural end of song
- cur_idx  out  SEQ_AW  index of the entry being loaded or played

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE.
  - tone_out=0, busy=0, done=0, cur_idx=0, all counters cleared.
  - RAM contents are undefined after reset; they are not cleared.
- Pitch table (half-period in clk cycles), indexed by note:
  - 0:95565, 1:85129, 2:75842, 3:71585, 4:63775, 5:56817
  - 6:50619, 7:45125, 8:40191, 9:33782, 10:30083, 11:26823
  - 12–15: rest.
  - Effective half-period = table >> octave (logical shift, HP_W bits).
- Writes:
  - Accepted in any state, one entry per cycle.
  - The currently playing note is latched, so overwriting its entry does not affect it.
- States: IDLE, LOAD, PLAY, END.
- IDLE:
  - tone_out=0.
  - start && !stop -> LOAD with cur_idx=0.
- LOAD:
  - Exactly 2 cycles (synchronous RAM read).
  - On the second cycle, evaluate the entry:
    - dur==0 (end marker) -> END.
    - Otherwise latch half-period and rest flag, set dur_cnt=dur, tick_cnt=0, tone_cnt=0, tone_out=0 -> PLAY.
- PLAY:
  - Lasts exactly dur*TICK_DIV cycles.
  - tone_cnt increments each cycle. When tone_cnt==half_period-1, it clears and tone_out toggles (non-rest only). First rising edge occurs half_period cycles after PLAY entry.
  - Rest: tone_out held 0.
  - tick_cnt wraps at TICK_DIV-1; each wrap decrements dur_cnt.
  - On the wrap that takes dur_cnt to 0:
    - If cur_idx==2^SEQ_AW-1 -> END.
    - Otherwise cur_idx+1 -> LOAD.
- END:
  - loop_en=1 and the song played at least one note since start -> cur_idx=0 -> LOAD.
  - Otherwise (loop_en=0, or an empty song, which prevents a lockup) -> done=1 for one cycle -> IDLE.
  - cur_idx holds its last value in IDLE.
- stop:
  - In any state, stop forces IDLE on the next edge with tone_out=0.
  - No done pulse is generated.
  - start in the same cycle is ignored.
- start while busy: ignored.
- loop_en is sampled only in END.

Test Plan:
1. Reset asserted 3 cycles mid-PLAY -> next cycle tone_out=0, busy=0, done=0, cur_idx=0; RAM writes after reset are accepted.
2. TICK_DIV=8000, SEQ_AW=3; entry0={11,3,1}, entry1={0,0,0}; loop_en=0; start pulse:
   - busy=1 next cycle.
   - tone_out rises 3352 cycles after PLAY entry and falls at 6704.
   - cur_idx goes 0 then 1.
   - done pulses once, 8000+4 cycles after LOAD start.
   - busy drops the same edge done falls.
3. Rest entry0={12,0,1}, entry1 end marker -> tone_out stays 0 for the whole note; cur_idx advances to 1; done pulses.
4. loop_en=1, entries {0,3,1},{5,2,1}, end marker:
   - cur_idx sequence 0,1,0,1…
   - done never asserts.
   - stop mid-note -> IDLE next cycle, tone_out=0, done=0.
5. start and stop asserted together in IDLE -> stays IDLE, busy=0. entry0 end marker with loop_en=1 -> done pulse after the 2-cycle LOAD, then IDLE (no lockup).
6. All 8 entries {3,3,1}, loop_en=0 -> cur_idx reaches 7 and done pulses after index 7 without wrapping. Overwriting entry 3 while it plays does not change its period.

Source files
------------

// File: rtl/tone_sequencer.sv
// Melody sequencer: steps through a writable note RAM on a duration tick and
// drives a square-wave tone whose half-period comes from a note/octave table.
module tone_sequencer #(
    parameter int unsigned SEQ_AW   = 5,
    parameter int unsigned HP_W     = 32,
    parameter int unsigned TICK_DIV = 2500000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SEQ_AW-1:0] wr_addr,
    input  logic [9:0]        wr_data,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    output logic              tone_out,
    output logic              busy,
    output logic              done,
    output logic [SEQ_AW-1:0] cur_idx
);

    localparam int unsigned DEPTH = 1 << SEQ_AW;
    localparam int unsigned TW    = $clog2(TICK_DIV);
    localparam logic [SEQ_AW-1:0] LAST_IDX  = {SEQ_AW{1'b1}};
    localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StPlay, StEnd} state_t;

    logic [9:0]        r_mem [DEPTH];
    logic [9:0]        r_rd_data;
    state_t            r_state;
    logic [SEQ_AW-1:0] r_cur_idx;
    logic              r_load_cnt;
    logic              r_played;
    logic [HP_W-1:0]   r_half;
    logic              r_rest;
    logic [3:0]        r_dur_cnt;
    logic [TW-1:0]     r_tick_cnt;
    logic [HP_W-1:0]   r_tone_cnt;
    logic              r_tone;

    logic [3:0]        w_note;
    logic [1:0]        w_oct;
    logic [3:0]        w_dur;
    logic [HP_W-1:0]   w_pitch;
    logic [HP_W-1:0]   w_half;
    logic              w_rest;

    // Melody RAM: write port plus registered read of the current index.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[r_cur_idx];
    end

    assign w_note = r_rd_data[9:6];
    assign w_oct  = r_rd_data[5:4];
    assign w_dur  = r_rd_data[3:0];

    // Note-to-half-period lookup; notes 12..15 are rests.
    always_comb begin
        w_pitch = '0;
        w_rest  = 1'b0;
        case (w_note)
            4'd0:    w_pitch = HP_W'(95565);
            4'd1:    w_pitch = HP_W'(85129);
            4'd2:    w_pitch = HP_W'(75842);
            4'd3:    w_pitch = HP_W'(71585);
            4'd4:    w_pitch = HP_W'(63775);
            4'd5:    w_pitch = HP_W'(56817);
            4'd6:    w_pitch = HP_W'(50619);
            4'd7:    w_pitch = HP_W'(45125);
            4'd8:    w_pitch = HP_W'(40191);
            4'd9:    w_pitch = HP_W'(33782);
            4'd10:   w_pitch = HP_W'(30083);
            4'd11:   w_pitch = HP_W'(26823);
            default: w_rest  = 1'b1;
        endcase
    end

    assign w_half = w_pitch >> w_oct;

    // Playback FSM; the note's period and rest flag are latched at load time so
    // later RAM writes cannot disturb the note in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cur_idx  <= '0;
            r_load_cnt <= 1'b0;
            r_played   <= 1'b0;
            r_half     <= '0;
            r_rest     <= 1'b0;
            r_dur_cnt  <= '0;
            r_tick_cnt <= '0;
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (stop) begin
            r_state    <= StIdle;
            r_load_cnt <= 1'b0;
            r_tone     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_tone <= 1'b0;
                    if (start) begin
                        r_state    <= StLoad;
                        r_cur_idx  <= '0;
                        r_load_cnt <= 1'b0;
                        r_played   <= 1'b0;
                    end
                end
                StLoad: begin
                    if (!r_load_cnt) begin
                        r_load_cnt <= 1'b1;
                    end else begin
                        r_load_cnt <= 1'b0;
                        if (w_dur == 4'd0) begin
                            r_state <= StEnd;
                        end else begin
                            r_half     <= w_half;
                            r_rest     <= w_rest;
                            r_dur_cnt  <= w_dur;
                            r_tick_cnt <= '0;
                            r_tone_cnt <= '0;
                            r_tone     <= 1'b0;
                            r_played   <= 1'b1;
                            r_state    <= StPlay;
                        end
                    end
                end
                StPlay: begin
                    if (r_tone_cnt == r_half - HP_W'(1)) begin
                        r_tone_cnt <= '0;
                        if (!r_rest) begin
                            r_tone <= ~r_tone;
                        end
                    end else begin
                        r_tone_cnt <= r_tone_cnt + HP_W'(1);
                    end
                    if (r_tick_cnt == TICK_LAST) begin
                        r_tick_cnt <= '0;
                        r_dur_cnt  <= r_dur_cnt - 4'd1;
                        if (r_dur_cnt == 4'd1) begin
                            // Note finished: silence before the next entry.
                            r_tone <= 1'b0;
                            if (r_cur_idx == LAST_IDX) begin
                                r_state <= StEnd;
                            end else begin
                                r_cur_idx <= r_cur_idx + SEQ_AW'(1);
                                r_state   <= StLoad;
                            end
                        end
                    end else begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end
                StEnd: begin
                    // An empty song never loops, otherwise it would spin forever.
                    if (loop_en && r_played) begin
                        r_cur_idx <= '0;
                        r_state   <= StLoad;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign tone_out = r_tone;
    assign busy     = (r_state != StIdle);
    // High for the single END cycle that returns to IDLE without looping.
    assign done     = (r_state == StEnd) && !stop && !(loop_en && r_played);
    assign cur_idx  = r_cur_idx;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: stimulus pushes expected output-change events
// (signal, value, cycle) into a queue; a monitor pops and compares on change.
module tb_tone_sequencer;

    localparam int unsigned AW = 3;
    localparam int unsigned TD = 8000;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [9:0]    wr_data;
    logic          start;
    logic          stop;
    logic          loop_en;
    logic          tone_out;
    logic          busy;
    logic          done;
    logic [AW-1:0] cur_idx;

    tone_sequencer #(
        .SEQ_AW  (AW),
        .HP_W    (32),
        .TICK_DIV(TD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .tone_out(tone_out),
        .busy    (busy),
        .done    (done),
        .cur_idx (cur_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int val;
        int at;
    } ev_t;

    ev_t   exp_q[$];
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 1'b0;
    string kname[4] = '{"tone_out", "busy", "done", "cur_idx"};

    logic          p_tone;
    logic          p_busy;
    logic          p_done;
    logic [AW-1:0] p_idx;

    task automatic expect_ev(input int kind, input int val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    function automatic void got_ev(input int kind, input int val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got %s=%0d at cycle %0d, required no change",
                     kname[kind], val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.at != cyc) begin
                bad++;
                $display("FAIL event: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                         kname[kind], val, cyc, kname[e.kind], e.val, e.at);
            end
        end
    endfunction

    function automatic void check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endfunction

    // Monitor: every observed output change is matched against the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tone_out !== p_tone) got_ev(0, int'(tone_out));
            if (busy !== p_busy)     got_ev(1, int'(busy));
            if (done !== p_done)     got_ev(2, int'(done));
            if (cur_idx !== p_idx)   got_ev(3, int'(cur_idx));
        end
        p_tone <= tone_out;
        p_busy <= busy;
        p_done <= done;
        p_idx  <= cur_idx;
    end

    task automatic wr(input int a, input int note, input int oct, input int dur);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = {4'(note), 2'(oct), 4'(dur)};
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    int t0;

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("init_tone", int'(tone_out), 0);
        check("init_busy", int'(busy), 0);
        check("init_done", int'(done), 0);
        check("init_idx", int'(cur_idx), 0);
        @(negedge clk);
        mon_en = 1'b1;

        // Reset three cycles while a note is sounding (tone high).
        wr(0, 11, 3, 1);
        wr(1, 0, 0, 0);
        @(negedge clk);
        t0 = cyc + 1;
        expect_ev(1, 1, t0);
        expect_ev(0, 1, t0 + 3354);
        expect_ev(0, 0, t0 + 3401);
        expect_ev(1, 0, t0 + 3401);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(t0 + 3400);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_tone", int'(tone_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_idx", int'(cur_idx), 0);
        drain(100);

        // One note (11, oct 3 -> half 3352) then end marker, one-shot.
        wr(0, 11, 3, 1);
        wr(1, 0, 0, 0);
        @(negedge clk);
        t0 = cyc + 1;
        expect_ev(1, 1, t0);
        expect_ev(0, 1, t0 + 2 + 3352);
        expect_ev(0, 0, t0 + 2 + 6704);
        expect_ev(3, 1, t0 + 8002);
        expect_ev(2, 1, t0 + 8004);
        expect_ev(1, 0, t0 + 8005);
        expect_ev(2, 0, t0 + 8005);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(9000);
        check("idx_hold_idle", int'(cur_idx), 1);

        // Rest entry: tone stays low for the whole note.
        wr(0, 12, 0, 1);
        @(negedge clk);
        t0 = cyc + 1;
        expect_ev(1, 1, t0);
        expect_ev(3, 0, t0);
        expect_ev(3, 1, t0 + 8002);
        expect_ev(2, 1, t0 + 8004);
        expect_ev(1, 0, t0 + 8005);
        expect_ev(2, 0, t0 + 8005);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(9000);

        // Looping song, stopped in the middle of the second pass.
        wr(0, 0, 3, 1);
        wr(1, 5, 2, 1);
        wr(2, 0, 0, 0);
        loop_en = 1'b1;
        @(negedge clk);
        t0 = cyc + 1;
        expect_ev(1, 1, t0);
        expect_ev(3, 0, t0);
        expect_ev(3, 1, t0 + 8002);
        expect_ev(3, 2, t0 + 16004);
        expect_ev(3, 0, t0 + 16007);
        expect_ev(1, 0, t0 + 16100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(t0 + 16099);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_tone", int'(tone_out), 0);
        check("stop_busy", int'(busy), 0);
        drain(17000);

        // start together with stop in IDLE is ignored.
        @(negedge clk);
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("start_stop_busy_later", int'(busy), 0);

        // Empty song with looping enabled ends instead of spinning.
        wr(0, 0, 0, 0);
        @(negedge clk);
        t0 = cyc + 1;
        expect_ev(1, 1, t0);
        expect_ev(2, 1, t0 + 2);
        expect_ev(1, 0, t0 + 3);
        expect_ev(2, 0, t0 + 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(100);

        // Full RAM, one-shot; entry 3 rewritten to a short period mid-note.
        loop_en = 1'b0;
        for (int i = 0; i < 8; i++) wr(i, 3, 3, 1);
        @(negedge clk);
        t0 = cyc + 1;
        expect_ev(1, 1, t0);
        for (int k = 1; k < 8; k++) expect_ev(3, k, t0 + 8002 * k);
        expect_ev(2, 1, t0 + 64016);
        expect_ev(1, 0, t0 + 64017);
        expect_ev(2, 0, t0 + 64017);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_to(t0 + 2 + 3 * 8002 + 1000);
        wr(3, 11, 3, 1);
        drain(70000);
        check("final_idx", int'(cur_idx), 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
